// File: rtl/time_set_ctrl_pkg.sv
// Shared types and limits for the clock/alarm timekeeping controller.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HR   = 3'd1,
    SET_MIN  = 3'd2,
    SET_AHR  = 3'd3,
    SET_AMIN = 3'd4
  } mode_t;

  localparam int unsigned HR_MAX  = 23;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned SEC_MAX = 59;

  // Value a field takes after one increment with wrap at max.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button/tick inputs and time/alarm outputs of the timekeeping controller.
interface time_set_ctrl_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       btn_alarm;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [4:0] alm_hours;
  logic [5:0] alm_minutes;
  logic [2:0] mode;
  logic       alarm_en;
  logic       alarm_ring;

  modport master (
    output tick, btn_mode, btn_up, btn_down, btn_alarm,
    input  hours, minutes, seconds, alm_hours, alm_minutes, mode, alarm_en, alarm_ring
  );

  modport slave (
    input  tick, btn_mode, btn_up, btn_down, btn_alarm,
    output hours, minutes, seconds, alm_hours, alm_minutes, mode, alarm_en, alarm_ring
  );
endinterface

// File: rtl/time_set_ctrl_wrap_counter.sv
// Modulo (MAX+1) up/down counter with clear and increment carry-out.
module wrap_counter #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         carry
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && !dec) begin
      q_d = (q_q == MAXV) ? '0 : q_q + W'(1);
    end else if (dec && !inc) begin
      q_d = (q_q == '0) ? MAXV : q_q - W'(1);
    end
  end

  // A clear overrides the increment, so no carry escapes on that cycle.
  assign carry = inc && !dec && !clr && (q_q == MAXV);
  assign q     = q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Running time, alarm time, setting-mode FSM and alarm ring control.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned RING_SEC = 60
) (
  input  logic           clk,
  input  logic           rst,
  time_set_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(RING_SEC + 1);

  mode_t          state_q, state_d;
  logic           en_q, en_d;
  logic           ring_q, ring_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [4:0] hr, ahr;
  logic [5:0] mn, sc, amn;
  logic       sec_c, min_c, hr_c, ahr_c, amin_c;
  logic       run_time, tick_run, up_e, dn_e, trig;
  logic [5:0] nxt_min, nxt_hr;
  logic       unused_carry;

  assign run_time = (state_q != SET_HR) && (state_q != SET_MIN);
  assign tick_run = bus.tick && run_time;
  assign up_e     = bus.btn_up && !bus.btn_down && !bus.btn_mode;
  assign dn_e     = bus.btn_down && !bus.btn_up && !bus.btn_mode;

  wrap_counter #(.MAX(SEC_MAX), .W(6)) u_sec (
    .clk(clk), .rst_n(rst),
    .inc(tick_run), .dec(1'b0), .clr(bus.btn_mode && (state_q == RUN)),
    .q(sc), .carry(sec_c)
  );

  wrap_counter #(.MAX(MIN_MAX), .W(6)) u_min (
    .clk(clk), .rst_n(rst),
    .inc(sec_c || ((state_q == SET_MIN) && up_e)),
    .dec((state_q == SET_MIN) && dn_e), .clr(1'b0),
    .q(mn), .carry(min_c)
  );

  // Manual minute wrap must not reach hours; time only runs outside SET_HR/SET_MIN.
  wrap_counter #(.MAX(HR_MAX), .W(5)) u_hr (
    .clk(clk), .rst_n(rst),
    .inc((min_c && run_time) || ((state_q == SET_HR) && up_e)),
    .dec((state_q == SET_HR) && dn_e), .clr(1'b0),
    .q(hr), .carry(hr_c)
  );

  wrap_counter #(.MAX(MIN_MAX), .W(6)) u_amin (
    .clk(clk), .rst_n(rst),
    .inc((state_q == SET_AMIN) && up_e),
    .dec((state_q == SET_AMIN) && dn_e), .clr(1'b0),
    .q(amn), .carry(amin_c)
  );

  wrap_counter #(.MAX(HR_MAX), .W(5)) u_ahr (
    .clk(clk), .rst_n(rst),
    .inc((state_q == SET_AHR) && up_e),
    .dec((state_q == SET_AHR) && dn_e), .clr(1'b0),
    .q(ahr), .carry(ahr_c)
  );

  assign unused_carry = hr_c ^ ahr_c ^ amin_c;

  // Compare against the time this tick is about to produce, so ring rises with it.
  assign nxt_min = wrap_inc(mn, 6'(MIN_MAX));
  assign nxt_hr  = (mn == 6'(MIN_MAX)) ? wrap_inc({1'b0, hr}, 6'(HR_MAX)) : {1'b0, hr};
  assign trig    = sec_c && en_q && (nxt_min == amn) && (nxt_hr == {1'b0, ahr});

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (bus.btn_mode) state_d = SET_HR;
      SET_HR:   if (bus.btn_mode) state_d = SET_MIN;
      SET_MIN:  if (bus.btn_mode) state_d = SET_AHR;
      SET_AHR:  if (bus.btn_mode) state_d = SET_AMIN;
      SET_AMIN: if (bus.btn_mode) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    en_d   = en_q;
    ring_d = ring_q;
    cnt_d  = cnt_q;
    if (ring_q && bus.tick) begin
      if (cnt_q == CW'(RING_SEC - 1)) begin
        ring_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (trig) begin
      ring_d = 1'b1;
      cnt_d  = '0;
    end
    if (bus.btn_alarm) begin
      if (ring_q || trig) begin
        ring_d = 1'b0;
        cnt_d  = '0;
      end else begin
        en_d = !en_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      en_q    <= 1'b0;
      ring_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      ring_q  <= ring_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.hours       = hr;
  assign bus.minutes     = mn;
  assign bus.seconds     = sc;
  assign bus.alm_hours   = ahr;
  assign bus.alm_minutes = amn;
  assign bus.mode        = state_q;
  assign bus.alarm_en    = en_q;
  assign bus.alarm_ring  = ring_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expected snapshots queued at drive time, popped after the edge.
module tb_time_set_ctrl;

  typedef struct packed {
    logic [4:0] hr;
    logic [5:0] mn;
    logic [5:0] sc;
    logic [4:0] ahr;
    logic [5:0] amn;
    logic [2:0] md;
    logic       en;
    logic       ring;
  } snap_t;

  logic clk;
  logic rst;
  time_set_ctrl_if bus ();

  time_set_ctrl #(.RING_SEC(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  snap_t sb[$];
  snap_t got, want;

  logic [4:0] e_hr, e_ahr;
  logic [5:0] e_min, e_sec, e_amin;
  logic [2:0] e_md;
  logic       e_en, e_ring;

  function automatic snap_t cur();
    return '{hr: bus.hours, mn: bus.minutes, sc: bus.seconds, ahr: bus.alm_hours,
             amn: bus.alm_minutes, md: bus.mode, en: bus.alarm_en, ring: bus.alarm_ring};
  endfunction

  function automatic snap_t expv();
    return '{hr: e_hr, mn: e_min, sc: e_sec, ahr: e_ahr, amn: e_amin,
             md: e_md, en: e_en, ring: e_ring};
  endfunction

  task automatic exp_clear();
    e_hr = '0; e_min = '0; e_sec = '0; e_ahr = '0; e_amin = '0;
    e_md = '0; e_en = 1'b0; e_ring = 1'b0;
  endtask

  // Expected running time one tick later.
  task automatic adv();
    if (e_sec == 6'd59) begin
      e_sec = '0;
      if (e_min == 6'd59) begin
        e_min = '0;
        e_hr  = (e_hr == 5'd23) ? 5'd0 : e_hr + 5'd1;
      end else e_min = e_min + 6'd1;
    end else e_sec = e_sec + 6'd1;
  endtask

  task automatic cycle(input logic t, input logic m, input logic u, input logic d, input logic a);
    bus.tick = t; bus.btn_mode = m; bus.btn_up = u; bus.btn_down = d; bus.btn_alarm = a;
    @(posedge clk);
    #1;
    bus.tick = 0; bus.btn_mode = 0; bus.btn_up = 0; bus.btn_down = 0; bus.btn_alarm = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_clear();
  endtask

  task automatic test_reset();
    do_reset();
    sb.push_back(expv());
    got = cur(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL reset got=%p exp=%p", got, want); end
  endtask

  task automatic test_rollover();
    for (int i = 1; i <= 86400; i++) begin
      e_hr  = 5'((i / 3600) % 24);
      e_min = 6'((i / 60) % 60);
      e_sec = 6'(i % 60);
      sb.push_back(expv());
      cycle(1, 0, 0, 0, 0);
      got = cur(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL rollover[%0d] got=%p exp=%p", i, got, want); end
    end
  endtask

  task automatic test_manual_set();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) e_md = 3'd1;
      if (i == 1) e_hr = 5'd23;
      if (i == 3) e_md = 3'd2;
      sb.push_back(expv());
      case (i)
        0: cycle(0, 1, 0, 0, 0);
        1: cycle(0, 0, 0, 1, 0);
        2: cycle(1, 0, 0, 0, 0);
        3: cycle(0, 1, 0, 0, 0);
        default: cycle(1, 0, 0, 0, 0);
      endcase
      got = cur(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL set_hour[%0d] got=%p exp=%p", i, got, want); end
    end
    for (int k = 1; k <= 61; k++) begin
      e_min = 6'(k % 60);
      sb.push_back(expv());
      cycle(1, 0, 1, 0, 0);
      got = cur(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL set_min[%0d] got=%p exp=%p", k, got, want); end
    end
  endtask

  // From RUN: step to SET_AMIN (clearing seconds), bump alarm minutes, optionally arm, back to RUN.
  task automatic set_alarm_min(input logic arm);
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        e_md = 3'(i + 1);
        if (i == 0) e_sec = '0;
        sb.push_back(expv());
        cycle(0, 1, 0, 0, 0);
      end else if (i == 4) begin
        e_amin = e_amin + 6'd1;
        sb.push_back(expv());
        cycle(0, 0, 1, 0, 0);
      end else if (i == 5) begin
        if (arm) e_en = 1'b1;
        sb.push_back(expv());
        cycle(0, 0, 0, 0, arm);
      end else begin
        e_md = 3'd0;
        sb.push_back(expv());
        cycle(0, 1, 0, 0, 0);
      end
      got = cur(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL alarm_setup[%0d] got=%p exp=%p", i, got, want); end
    end
  endtask

  task automatic run_to_ring();
    for (int i = 1; i <= 60; i++) begin
      adv();
      e_ring = (i == 60);
      sb.push_back(expv());
      cycle(1, 0, 0, 0, 0);
      got = cur(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL to_ring[%0d] got=%p exp=%p", i, got, want); end
    end
  endtask

  task automatic test_alarm_fire();
    do_reset();
    set_alarm_min(1'b1);
    run_to_ring();
    for (int k = 1; k <= 5; k++) begin
      adv();
      e_ring = (k < 5);
      sb.push_back(expv());
      cycle(1, 0, 0, 0, 0);
      got = cur(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL ring_timeout[%0d] got=%p exp=%p", k, got, want); end
    end
  endtask

  task automatic test_silence();
    set_alarm_min(1'b0);
    run_to_ring();
    e_ring = 1'b0;
    sb.push_back(expv());
    cycle(0, 0, 0, 0, 1);
    got = cur(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL silence got=%p exp=%p", got, want); end
    set_alarm_min(1'b0);
    for (int i = 1; i <= 60; i++) begin
      adv();
      sb.push_back(expv());
      cycle(1, 0, 0, 0, i == 60);
      got = cur(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL trig_and_silence[%0d] got=%p exp=%p", i, got, want); end
    end
  endtask

  task automatic test_simul_buttons();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        e_md = 3'(i + 1);
        if (i == 0) e_sec = '0;
        sb.push_back(expv());
        cycle(0, 1, 0, 0, 0);
      end else if (i == 4) begin
        sb.push_back(expv());
        cycle(0, 0, 1, 1, 0);
      end else begin
        e_md = 3'd0;
        sb.push_back(expv());
        cycle(0, 1, 1, 0, 0);
      end
      got = cur(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL simul_buttons[%0d] got=%p exp=%p", i, got, want); end
    end
  endtask

  task automatic test_reset_mid();
    set_alarm_min(1'b0);
    run_to_ring();
    for (int i = 0; i < 2; i++) begin
      e_md = 3'(i + 1);
      if (i == 0) e_sec = '0;
      sb.push_back(expv());
      cycle(0, 1, 0, 0, 0);
      got = cur(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL pre_reset[%0d] got=%p exp=%p", i, got, want); end
    end
    #2;
    rst = 1'b0;
    exp_clear();
    sb.push_back(expv());
    #1;
    got = cur(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL async_reset got=%p exp=%p", got, want); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.push_back(expv());
    cycle(0, 0, 0, 0, 0);
    got = cur(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL after_reset got=%p exp=%p", got, want); end
  endtask

  initial begin
    rst = 1'b0;
    bus.tick = 0; bus.btn_mode = 0; bus.btn_up = 0; bus.btn_down = 0; bus.btn_alarm = 0;
    exp_clear();
    test_reset();
    test_rollover();
    test_manual_set();
    test_alarm_fire();
    test_silence();
    test_simul_buttons();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Timekeeping and setting controller for the digital clock/alarm. It consumes the single-cycle debounced pulses produced by the `Pushbutton` stage and a 1 Hz enable tick. It maintains the running time (HH:MM:SS, 24 h) and the alarm time (HH:MM), and walks a mode FSM for setting both. It raises `alarm_ring` when the running time reaches the enabled alarm time. Outputs feed the display multiplexer and buzzer driver.

## Interface
- `RING_SEC`, default 60: number of ticks `alarm_ring` stays high unless silenced.
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle 1 Hz enable pulse.
- `btn_mode` in 1: one-cycle pulse (from `Pushbutton`); advances mode.
- `btn_up` in 1: one-cycle pulse; increments the selected field.
- `btn_down` in 1: one-cycle pulse; decrements the selected field.
- `btn_alarm` in 1: one-cycle pulse; toggles the alarm enable, or silences the alarm while it is ringing.
- `hours` out 5: running hours, 0–23.
- `minutes` out 6: running minutes, 0–59.
- `seconds` out 6: running seconds, 0–59.
- `alm_hours` out 5: alarm hours, 0–23.
- `alm_minutes` out 6: alarm minutes, 0–59.
- `mode` out 3: current FSM state encoding.
- `alarm_en` out 1: alarm armed.
- `alarm_ring` out 1: alarm sounding.

## Operation
- **FSM states:** RUN=0, SET_HR=1, SET_MIN=2, SET_AHR=3, SET_AMIN=4. Encodings 5–7 are illegal and recover to RUN.
- **Mode advance:** `btn_mode` steps RUN→SET_HR→SET_MIN→SET_AHR→SET_AMIN→RUN.
- **Seconds on set:** entering SET_HR clears `seconds` to 0.
- **Time during set:** in SET_HR and SET_MIN, `tick` is ignored and the time is frozen. In all other states the time runs.
- **Tick increment:** seconds 59→0 carries into minutes; minutes 59→0 carries into hours; hours 23→0.
- **Up/down field select:** `btn_up` and `btn_down` modify only the field selected by state: hours, minutes, alarm hours, or alarm minutes. They have no effect in RUN.
- **Up/down wrap:** both directions wrap modulo 24 or 60. There is no carry between fields.
- **Alarm compare:** when a tick advances the running time to `seconds`==0 and {`hours`,`minutes`}=={`alm_hours`,`alm_minutes`}, and `alarm_en`=1, `alarm_ring` sets. A time reached by manual setting never triggers the alarm.
- **Ring duration:** while ringing, the ring counter counts ticks. After `RING_SEC` ticks, `alarm_ring` clears.
- **`btn_alarm` while ringing:** clears `alarm_ring` and leaves `alarm_en` unchanged.
- **`btn_alarm` otherwise:** toggles `alarm_en`. Clearing `alarm_en` also clears `alarm_ring`.
- **Priorities in the same cycle:**
  - `btn_mode` beats `btn_up`/`btn_down`; the field change is dropped.
  - `btn_up` together with `btn_down`: no change.
  - `tick` in SET_AHR/SET_AMIN together with up/down: both applied, since they touch disjoint registers.
  - Alarm trigger together with `btn_alarm`: the silence wins, and `alarm_ring` stays 0.
- **Reset:** async assertion at any time, including mid-ring or mid-set. It forces:
  - state RUN;
  - time 00:00:00;
  - alarm 00:00;
  - `alarm_en`=0, `alarm_ring`=0, ring counter 0.

## Timing
- All outputs are registered. Every input pulse takes effect on the posedge where it is sampled high, so the result is visible the following cycle.
- Pulses are assumed to be exactly one cycle wide. A held-high input acts once per cycle and is not filtered here.
- `alarm_ring` rises one cycle after the triggering tick cycle. It falls one cycle after the `RING_SEC`-th subsequent tick or after a silencing `btn_alarm`.
- The ring counter width is $clog2(`RING_SEC`+1).

## Structure
- Shared package `clock_pkg`:
  - state enum `mode_t`;
  - constants `HR_MAX`=23, `MIN_MAX`=59, `SEC_MAX`=59.
- Sub-module `wrap_counter`:
  - parameters `MAX` and `W`;
  - inputs `inc`, `dec`, `clr`;
  - `carry` out on `inc` at `MAX`;
  - async active-low reset.
- Instantiate `wrap_counter` five times: seconds, minutes, hours, alarm minutes, alarm hours.
- The FSM, alarm compare and ring counter live in the top module.

## Test plan
- **Reset and full rollover:** release reset, then apply 86400 ticks in RUN → time goes 00:00:00→23:59:59→00:00:00, with `alarm_en`=0 and `alarm_ring`=0 throughout.
- **Manual time set:** `btn_mode` ×1, `btn_down` ×1 → `hours`=23. `btn_mode`, then `btn_up` ×61 → `minutes`=1. Ticks during this sequence leave `seconds`=0.
- **Alarm fires and times out:** set the alarm to 00:01, pulse `btn_alarm`, return to RUN, then apply 60 ticks → `alarm_ring`=1 one cycle after the 60th tick, and clears after a further `RING_SEC` ticks.
- **Silence while ringing:** `btn_alarm` while ringing → `alarm_ring`=0 next cycle and `alarm_en` stays 1. Next, a trigger tick and `btn_alarm` in the same cycle → `alarm_ring` stays 0.
- **Simultaneous buttons:** in SET_AMIN, `btn_up` and `btn_down` together → no change. `btn_mode` and `btn_up` together → state RUN and `alm_minutes` unchanged.
- **Reset mid-operation:** async `rst` low mid-cycle during SET_MIN with ringing active → all outputs return to their reset values immediately, without waiting for a clock edge.
